hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sequences the registered EX-stage ALU.
- Produces ALU operand-forwarding selects for the next EX cycle.
- Inserts load-use bubbles and flushes wrong-path instructions after the ALU's registered pcsrc resolves a taken beq/jal.
- Sits beside the ID/EX pipeline registers and drives PC, IF/ID and ID/EX write/flush controls.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles the flush outputs stay high after pcsrc is sampled high (legal 1..7).
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- ex_rd  in  5  destination register of instruction in EX
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load
- mem_rd  in  5  destination register of instruction in MEM
- mem_regwrite  in  1  MEM instruction writes a register
- pcsrc  in  1  taken-branch/jal indication from ALU (registered)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  clear ID/EX to bubble
- forward_a  out  2  ALU operand A select: 00 regfile, 01 WB value, 10 MEM value
- forward_b  out  2  ALU operand B select, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  flush cycles, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, flush counter=0.
  - forward_a/forward_b=00, stall_cnt=0, flush_cnt=0.
  - Combinational outputs in RUN: pc_write=1, ifid_write=1, flushes=0.
  - Reset mid-flush or mid-stall returns to RUN immediately; no residual flush.
- States:
  - RUN: normal issue.
  - STALL: one bubble cycle.
  - FLUSH: counting down wrong-path cycles.
- Load-use detect (combinational): ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Transitions, evaluated at posedge:
  - pcsrc=1 in any state -> FLUSH, counter=FLUSH_CYCLES-1. Highest priority.
  - pcsrc=1 again during FLUSH reloads the counter.
  - RUN & load-use -> STALL.
  - STALL -> RUN after exactly one cycle.
  - FLUSH with counter==0 -> RUN; otherwise decrement.
  - Load-use seen in FLUSH is ignored, because that instruction is being discarded.
- Outputs (Moore, from state):
  - RUN: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
  - STALL: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
  - FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
- Forwarding selects are registered, computed from ID-stage operands so they are valid while that instruction is in EX.
  - Next-cycle MEM source is the current EX instruction; next-cycle WB source is the current MEM instruction.
  - forward_x <= 10 if ex_regwrite & ex_rd!=0 & ex_rd==id_rsx.
  - Else forward_x <= 01 if mem_regwrite & mem_rd!=0 & mem_rd==id_rsx.
  - Else forward_x <= 00.
  - MEM match has priority over WB, so the youngest producer wins.
  - When the next state is STALL or FLUSH, the registered forward selects are forced to 00 (bubble in EX).
  - On the cycle leaving STALL, selects are recomputed; the load is then in MEM, so 10 is not legal, and the result comes via WB as 01 in the following cycle.
  - Corrected rule for that cycle: in STALL, compare id_rsx against mem_rd (the load now in MEM); a match yields 01.
- Register x0 never forwards or stalls.
- Counters:
  - stall_cnt increments each cycle in STALL.
  - flush_cnt increments each cycle in FLUSH.
  - Both saturate at all-ones.
- Latency: pcsrc high at edge N gives flush outputs high for cycles N+1 .. N+FLUSH_CYCLES.

Decomposition:
- Shared header cpu_defs: forward encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; state encodings RUN/STALL/FLUSH; REG_ZERO=5'd0.
- One natural sub-module, fwd_sel, instantiated twice (once per operand):
  - inputs: rs, ex_rd, ex_regwrite, mem_rd, mem_regwrite, stall_state
  - output: next 2-bit select

Test Plan:
- Reset: rst_n low mid-FLUSH (counter=1) -> all outputs return to reset values asynchronously; after release, pc_write=1, flush_cnt holds 0.
- Back-to-back ALU dependence: EX add x5 (ex_rd=5, ex_regwrite=1), ID rs1=5 -> next cycle forward_a=10, forward_b=00; same rd in MEM only -> forward_a=01.
- Load-use: ex_memread=1, ex_rd=7, id_rs2=7 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1; then forward_b=01 and RUN.
- x0 guard: ex_rd=0, ex_memread=1, id_rs1=0 -> no stall, forward_a=00.
- Taken branch: pcsrc pulse at edge N -> ifid_flush=idex_flush=1 for exactly 2 cycles; flush_cnt=2; pcsrc repeated at N+1 -> flush extends to N+3.
- Priority: pcsrc=1 together with a load-use condition -> FLUSH entered, no STALL, stall_cnt unchanged.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forwarding selects, FSM
// state encodings and the register-match helper used by both operands.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer only counts if it writes a real register (x0 is hardwired).
  function automatic logic reg_match(input logic wr, input logic [4:0] rd,
                                     input logic [4:0] rs);
    return wr && (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Next-cycle forwarding select for one ALU operand of the instruction in ID.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       stall_state,
  output logic [1:0] sel
);

  // While stalled the load has already moved to MEM, so only a WB path is legal.
  always_comb begin
    sel = FWD_REG;
    if (stall_state) begin
      if (reg_match(mem_regwrite, mem_rd, rs)) sel = FWD_WB;
      else                                     sel = FWD_REG;
    end else if (reg_match(ex_regwrite, ex_rd, rs)) begin
      sel = FWD_MEM;
    end else if (reg_match(mem_regwrite, mem_rd, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// registered ALU forwarding selects for the next EX cycle.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             pcsrc,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state, state_next;
  logic [2:0] fcnt, fcnt_next;
  logic       load_use;
  logic [1:0] fa_next, fb_next;

  assign load_use = ex_memread && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Next-state: a resolved branch overrides everything, including a pending stall.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    if (pcsrc) begin
      state_next = ST_FLUSH;
      fcnt_next  = FLUSH_LOAD;
    end else begin
      case (state)
        ST_RUN: begin
          if (load_use) state_next = ST_STALL;
          else          state_next = ST_RUN;
        end
        ST_STALL: state_next = ST_RUN;
        ST_FLUSH: begin
          if (fcnt == 3'd0) state_next = ST_RUN;
          else              fcnt_next  = fcnt - 3'd1;
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // Moore pipeline controls decoded from the state register.
  always_comb begin
    case (state)
      ST_STALL: {pc_write, ifid_write, ifid_flush, idex_flush} = 4'b0001;
      ST_FLUSH: {pc_write, ifid_write, ifid_flush, idex_flush} = 4'b1111;
      default:  {pc_write, ifid_write, ifid_flush, idex_flush} = 4'b1100;
    endcase
  end

  hazard_ctrl_fwd_sel u_fwd_a (
    .rs           (id_rs1),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .stall_state  (state == ST_STALL),
    .sel          (fa_next)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .rs           (id_rs2),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .stall_state  (state == ST_STALL),
    .sel          (fb_next)
  );

  // State, flush countdown and forwarding selects; a bubble in EX never forwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      fcnt      <= 3'd0;
      forward_a <= FWD_REG;
      forward_b <= FWD_REG;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
      if (state_next != ST_RUN) begin
        forward_a <= FWD_REG;
        forward_b <= FWD_REG;
      end else begin
        forward_a <= fa_next;
        forward_b <= fb_next;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == ST_STALL) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == ST_FLUSH) && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table of single-cycle cases plus
// hand sequences for stall, flush length, branch priority and async reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0, mem_rd = 5'd0;
  logic        ex_regwrite = 1'b0, ex_memread = 1'b0, mem_regwrite = 1'b0, pcsrc = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .pcsrc(pcsrc),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .forward_a(forward_a), .forward_b(forward_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw, pcsrc;
    logic [1:0] fa, fb;
    logic [3:0] ctl;   // {pc_write, ifid_write, ifid_flush, idex_flush}
  } vec_t;

  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;

  vec_t vecs[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0; pcsrc = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] ctl_now();
    return {12'd0, pc_write, ifid_write, ifid_flush, idex_flush};
  endfunction

  initial begin
    //          rs1    rs2    ex_rd  rw    mr    mem_rd mrw  pcsrc  fa     fb     ctl
    vecs[0] = '{5'd5,  5'd6,  5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2'b10, 2'b00, C_RUN};
    vecs[1] = '{5'd5,  5'd6,  5'd9,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 2'b01, 2'b00, C_RUN};
    vecs[2] = '{5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 2'b10, 2'b10, C_RUN};
    vecs[3] = '{5'd4,  5'd3,  5'd3,  1'b1, 1'b0, 5'd4,  1'b1, 1'b0, 2'b01, 2'b10, C_RUN};
    vecs[4] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 2'b00, 2'b00, C_RUN};
    vecs[5] = '{5'd5,  5'd6,  5'd5,  1'b0, 1'b0, 5'd6,  1'b0, 1'b0, 2'b00, 2'b00, C_RUN};
    vecs[6] = '{5'd1,  5'd7,  5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 2'b00, 2'b00, C_STALL};
    vecs[7] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 2'b00, C_FLUSH};
    vecs[8] = '{5'd1,  5'd7,  5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 2'b00, 2'b00, C_FLUSH};

    // Reset values while rst_n is held low
    #3;
    check("rst_ctl", ctl_now(), {12'd0, C_RUN});
    check("rst_fa", {14'd0, forward_a}, 16'd0);
    check("rst_fb", {14'd0, forward_b}, 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_flush_cnt", flush_cnt, 16'd0);
    #4 rst_n = 1'b1;
    tick();

    // Table: each vector starts in RUN, takes one edge, then drains back to RUN
    for (int i = 0; i < 9; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].ex_rd;
      ex_regwrite = vecs[i].ex_rw; ex_memread = vecs[i].ex_mr;
      mem_rd = vecs[i].mem_rd; mem_regwrite = vecs[i].mem_rw; pcsrc = vecs[i].pcsrc;
      tick();
      check($sformatf("vec%0d_fa", i), {14'd0, forward_a}, {14'd0, vecs[i].fa});
      check($sformatf("vec%0d_fb", i), {14'd0, forward_b}, {14'd0, vecs[i].fb});
      check($sformatf("vec%0d_ctl", i), ctl_now(), {12'd0, vecs[i].ctl});
      idle();
      tick(); tick(); tick();
    end

    // Load-use on rs2: one bubble, then WB forward once the load is in MEM
    do_reset();
    id_rs1 = 5'd1; id_rs2 = 5'd7; ex_rd = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1;
    tick();
    check("lu_stall_ctl", ctl_now(), {12'd0, C_STALL});
    check("lu_stall_cnt0", stall_cnt, 16'd0);
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = 5'd7; mem_regwrite = 1'b1;
    tick();
    check("lu_run_ctl", ctl_now(), {12'd0, C_RUN});
    check("lu_fb_wb", {14'd0, forward_b}, 16'd1);
    check("lu_fa_reg", {14'd0, forward_a}, 16'd0);
    check("lu_stall_cnt1", stall_cnt, 16'd1);

    // Single pcsrc pulse: exactly two flush cycles
    do_reset();
    pcsrc = 1'b1;
    tick();
    pcsrc = 1'b0;
    check("br_c1", ctl_now(), {12'd0, C_FLUSH});
    tick();
    check("br_c2", ctl_now(), {12'd0, C_FLUSH});
    tick();
    check("br_c3_run", ctl_now(), {12'd0, C_RUN});
    check("br_flush_cnt", flush_cnt, 16'd2);

    // Repeated pcsrc reloads the countdown: flush through N+3
    do_reset();
    pcsrc = 1'b1;
    tick();
    check("rep_c1", ctl_now(), {12'd0, C_FLUSH});
    tick();
    pcsrc = 1'b0;
    check("rep_c2", ctl_now(), {12'd0, C_FLUSH});
    tick();
    check("rep_c3", ctl_now(), {12'd0, C_FLUSH});
    tick();
    check("rep_c4_run", ctl_now(), {12'd0, C_RUN});
    check("rep_flush_cnt", flush_cnt, 16'd3);

    // Branch beats load-use; load-use during FLUSH is ignored
    do_reset();
    id_rs2 = 5'd7; ex_rd = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1; pcsrc = 1'b1;
    tick();
    pcsrc = 1'b0;
    check("pri_flush", ctl_now(), {12'd0, C_FLUSH});
    tick();
    check("pri_flush2", ctl_now(), {12'd0, C_FLUSH});
    tick();
    check("pri_run", ctl_now(), {12'd0, C_RUN});
    check("pri_stall_cnt", stall_cnt, 16'd0);
    idle();

    // Async reset in the middle of a flush (countdown still 1)
    do_reset();
    pcsrc = 1'b1;
    tick();
    pcsrc = 1'b0;
    check("mid_flush_pre", ctl_now(), {12'd0, C_FLUSH});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", ctl_now(), {12'd0, C_RUN});
    check("mid_rst_flush_cnt", flush_cnt, 16'd0);
    #2 rst_n = 1'b1;
    tick();
    check("mid_post_ctl", ctl_now(), {12'd0, C_RUN});
    check("mid_post_flush_cnt", flush_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
